sram_controller: RTL and testbench

- Sequences every data-memory access from the MEM stage onto the external 64-bit asynchronous SRAM (`SRAM_DQ` / `SRAM_ADDR` / `SRAM_WE_N`).
- Converts 32-bit CPU word reads and writes into fixed-wait-state SRAM cycles. Writes use read-modify-write because the SRAM has no byte enables.
- Drives `ready`; the pipeline freezes IF/ID/EXE/MEM registers while `ready` is low.

---
 rtl/sram_controller_pkg.sv | 31 +++
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_controller.sv | 111 +++++++++++
 tb/tb_sram_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared widths, FSM state encoding and the line-merge helper for the
// data-memory SRAM controller.
package sram_controller_pkg;

    localparam int SRAM_DATA   = 64;
    localparam int SRAM_ADDR_W = 17;
    localparam int WORD        = 32;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        SRAM_IDLE     = 3'd0,
        SRAM_RD       = 3'd1,
        SRAM_WR_READ  = 3'd2,
        SRAM_WR_WRITE = 3'd3,
        SRAM_DONE     = 3'd4
    } sram_state_e;

    // Replace one 32-bit half of a 64-bit line, keeping the other half intact.
    function automatic logic [SRAM_DATA-1:0] merge_half(
        input logic [SRAM_DATA-1:0] line,
        input logic [WORD-1:0]      word,
        input logic                 hsel
    );
        logic [SRAM_DATA-1:0] merged;
        merged = line;
        if (hsel) merged[63:32] = word;
        else      merged[31:0]  = word;
        return merged;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM phase: counts 0..WAIT_CYCLES-1 and flags
// the final count so the controller knows when the phase ends.
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear)       count_d = '0;
        else if (enable) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign last = (count_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Sequences CPU word loads/stores onto a 64-bit asynchronous SRAM with fixed
// wait states; stores are read-modify-write since the SRAM has no byte enables.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [WORD-1:0]        address,
    input  logic [WORD-1:0]        write_data,
    output logic [WORD-1:0]        read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    // Handshake: a request is held on mem_read/mem_write while ready is low;
    // the cycle ready returns high (DONE) completes it and the request drops.

    sram_state_e state_q, state_d;

    logic [SRAM_ADDR_W-1:0] addr_q;
    logic                   hsel_q;
    logic [WORD-1:0]        wdata_q;
    logic [SRAM_DATA-1:0]   line_q;
    logic [WORD-1:0]        read_data_q;

    logic [WORD-1:0]        offset;
    logic                   cnt_clear;
    logic                   cnt_enable;
    logic                   cnt_last;
    logic                   ready_fsm;
    logic [SRAM_DATA-1:0]   dq_in;

    assign offset = address - WORD'(BASE_ADDR);
    assign dq_in  = SRAM_DQ;

    always_comb begin
        state_d   = state_q;
        ready_fsm = 1'b0;
        case (state_q)
            SRAM_IDLE: begin
                ready_fsm = ~(mem_read | mem_write);
                if (mem_write)     state_d = SRAM_WR_READ;
                else if (mem_read) state_d = SRAM_RD;
            end
            SRAM_RD:       if (cnt_last) state_d = SRAM_DONE;
            SRAM_WR_READ:  if (cnt_last) state_d = SRAM_WR_WRITE;
            SRAM_WR_WRITE: if (cnt_last) state_d = SRAM_DONE;
            SRAM_DONE: begin
                ready_fsm = 1'b1;
                state_d   = SRAM_IDLE;
            end
            default: state_d = SRAM_IDLE;
        endcase
    end

    assign cnt_clear  = (state_d != state_q);
    assign cnt_enable = (state_q == SRAM_RD) || (state_q == SRAM_WR_READ) ||
                        (state_q == SRAM_WR_WRITE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SRAM_IDLE;
            addr_q      <= '0;
            hsel_q      <= 1'b0;
            wdata_q     <= '0;
            line_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SRAM_IDLE && state_d != SRAM_IDLE) begin
                addr_q  <= offset[19:3];
                hsel_q  <= offset[2];
                wdata_q <= write_data;
            end
            if (state_q == SRAM_RD && cnt_last) begin
                line_q      <= dq_in;
                read_data_q <= hsel_q ? dq_in[63:32] : dq_in[31:0];
            end
            if (state_q == SRAM_WR_READ && cnt_last) begin
                line_q      <= merge_half(dq_in, wdata_q, hsel_q);
                read_data_q <= wdata_q;
            end
        end
    end

    // Reset forces IDLE asynchronously, so WE_N and the DQ drivers release at once;
    // ready is also held high while reset is asserted.
    assign SRAM_WE_N = (state_q != SRAM_WR_WRITE);
    assign SRAM_DQ   = (state_q == SRAM_WR_WRITE) ? line_q : {SRAM_DATA{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign read_data = read_data_q;
    assign ready     = rst | ready_fsm;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: a behavioural SRAM on the bus plus a
// word-level reference memory that predicts load data, store results and latency.
module tb_sram_controller;

    localparam int          BASE   = 1024;
    localparam int          WAITC  = 5;
    localparam int          NWORDS = 131072;
    localparam logic [31:0] BASE32 = 32'(BASE);

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [63:0] sram_dq;
    logic [16:0] sram_addr;
    logic        sram_we_n;

    logic [63:0] sram_mem  [NWORDS];
    logic [63:0] model_mem [NWORDS];

    int checks   = 0;
    int failures = 0;

    sram_controller #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n)
    );

    // Asynchronous SRAM: drives the bus whenever not being written.
    assign sram_dq = sram_we_n ? sram_mem[sram_addr] : {64{1'bz}};

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [63:0] val);
        sram_mem[idx]  = val;
        model_mem[idx] = val;
    endtask

    // One complete access; both=1 asserts mem_read together with mem_write.
    task automatic do_access(input bit is_wr, input bit both, input logic [31:0] addr,
                             input logic [31:0] wd, input string tag);
        logic [31:0] off;
        int          word;
        bit          hs;
        int          cycles;
        int          we_low;
        int          we_first;
        bit          done;
        logic [31:0] exp_rd;
        off  = addr - BASE32;
        word = int'((off / 8) % NWORDS);
        hs   = ((off / 4) % 2) == 1;
        @(negedge clk);
        mem_read   = ~is_wr | both;
        mem_write  = is_wr;
        address    = addr;
        write_data = wd;
        #1;
        chk({tag, " ready_req"}, 64'(ready), 64'd0);
        cycles = 0; we_low = 0; we_first = 0; done = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) chk({tag, " sram_addr"}, 64'(sram_addr), 64'(word));
            if (!sram_we_n) begin
                we_low++;
                if (we_first == 0) we_first = cycles;
            end
            if (ready) done = 1;
        end
        chk({tag, " timeout"}, 64'(done), 64'd1);
        if (is_wr) begin
            if (hs) model_mem[word][63:32] = wd;
            else    model_mem[word][31:0]  = wd;
            exp_rd = wd;
            chk({tag, " latency"}, 64'(cycles), 64'(2 * WAITC + 1));
            chk({tag, " we_low_cycles"}, 64'(we_low), 64'(WAITC));
            chk({tag, " we_first"}, 64'(we_first), 64'(WAITC + 1));
            chk({tag, " sram_line"}, sram_mem[word], model_mem[word]);
        end else begin
            exp_rd = hs ? model_mem[word][63:32] : model_mem[word][31:0];
            chk({tag, " latency"}, 64'(cycles), 64'(WAITC + 1));
            chk({tag, " we_low_cycles"}, 64'(we_low), 64'd0);
        end
        chk({tag, " read_data"}, 64'(read_data), 64'(exp_rd));
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int          cnt;
        int          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          wr;
        bit          both;

        for (int i = 0; i < NWORDS; i++) set_word(i, 64'd0);
        for (int i = 0; i < 16; i++) set_word(i, {$urandom, $urandom});

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; write_data = '0;
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset we_n", 64'(sram_we_n), 64'd1);
        chk("reset sram_addr", 64'(sram_addr), 64'd0);
        chk("reset read_data", 64'(read_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 17'd0)
                chk("idle", {ready, sram_we_n, 15'd0, sram_addr}, {1'b1, 1'b1, 15'd0, 17'd0});
        end
        chk("idle ready", 64'(ready), 64'd1);

        set_word(0, 64'h11111111_22222222);
        set_word(1, 64'hAAAAAAAA_BBBBBBBB);
        do_access(0, 0, 32'd1024, 32'h0, "rd_lo");
        do_access(0, 0, 32'd1028, 32'h0, "rd_hi");
        do_access(1, 0, 32'd1036, 32'hDEADBEEF, "wr_merge");
        chk("wr_merge line", sram_mem[1], 64'hDEADBEEF_BBBBBBBB);
        do_access(1, 0, 32'd1024, 32'hCAFEF00D, "b2b_wr");
        do_access(0, 0, 32'd1024, 32'h0, "b2b_rd");
        do_access(1, 1, 32'd1044, 32'h12345678, "both_wr");
        do_access(0, 0, 32'd1044, 32'h0, "both_rd");
        do_access(1, 0, 32'd4, 32'h0BADC0DE, "wrap_wr");
        do_access(0, 0, 32'd4, 32'h0, "wrap_rd");

        for (int i = 0; i < 30; i++) begin
            wr   = $urandom_range(0, 1) == 1;
            both = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
            else a = BASE32 + 32'($urandom_range(0, 15) * 8) +
                     32'($urandom_range(0, 1) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            do_access(wr, both, a, d, "rand");
        end

        // Abort a store on its third write-phase cycle.
        set_word(2, 64'h55555555_66666666);
        @(negedge clk);
        mem_write = 1'b1; address = 32'd1048; write_data = 32'h77777777;
        cnt = 0; w = 0;
        while (w < 3 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (!sram_we_n) w++;
        end
        chk("rst_mid we_reached", 64'(w), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_mid we_n", 64'(sram_we_n), 64'd1);
        chk("rst_mid ready", 64'(ready), 64'd1);
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst ready", 64'(ready), 64'd1);
        do_access(0, 0, 32'd1024, 32'h0, "post_rst_rd");
        do_access(0, 0, 32'd1044, 32'h0, "post_rst_rd2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
